hdb3_b_polar: RTL and testbench
===============================

Name: hdb3_b_polar

Overview:
- Stage directly downstream of the V-insertion stage in the HDB3 encoder.
- Consumes its 2-bit symbol stream (00 zero, 01 mark, 11 V).
- Inserts the B violation where the "even marks since last V" rule requires it.
- Assigns line polarity and drives dual-rail P/N outputs to the line driver, plus the final 2-bit code for debug.

Parameters:
- INIT_POL, 1'b0, polarity of the virtual "previous pulse" after reset (0 = negative, so the first mark goes positive).

Ports:
- clk  input  1  symbol-rate clock; one symbol per cycle, no valid strobe.
- rst_n  input  1  synchronous active-low reset.
- data_v  input  2  upstream symbol code: 00 zero, 01 mark, 11 V, 10 illegal at this input.
- code_out  output  2  final symbol after B insertion: 00 zero, 01 mark, 10 B, 11 V.
- hdb3_p  output  1  positive-rail pulse.
- hdb3_n  output  1  negative-rail pulse.
- err  output  1  one-cycle flag: illegal input code, or V not preceded by three zeros.

Behaviour:
- Reset: when rst_n is low at a clk edge:
  - sr[0..2] (3-stage symbol shift register) := 00.
  - code_out := 00, hdb3_p := 0, hdb3_n := 0, err := 0.
  - mark_odd := 0; last_pol := INIT_POL.
  - Reset mid-stream discards all in-flight symbols.
- Pipeline:
  - Each edge: sr[0] <= data_v (10 is replaced by 00), sr[1] <= sr[0], sr[2] <= sr[1].
  - Output stage consumes sr[2] or its B-substituted value.
  - Latency: symbol sampled at edge k appears on code_out/hdb3_p/hdb3_n after edge k+3, i.e. the output lags data_v by 3 cycles.
- Parity tracking, evaluated on the input symbol:
  - 01 toggles mark_odd.
  - 11 clears mark_odd to 0.
  - 00 and 10 leave it unchanged.
- B insertion: when data_v = 11 and mark_odd = 0 (even marks since previous V, including zero marks) at the same edge:
  - if sr[0], sr[1], sr[2] are all 00, the symbol leaving sr[2] on that edge is output as 10 (B) instead of 00;
  - otherwise no substitution, err := 1 for one cycle.
  - The V itself is never modified.
- V with mark_odd = 1: no B; err := 1 if the three preceding symbols are not all 00.
- Reset-filled zeros count as zeros for the three-zero check.
- Illegal input 10: treated as 00 for all purposes; err := 1 the following cycle.
- Polarity, applied to the symbol being output:
  - 00: p = n = 0; last_pol unchanged.
  - 01 or 10: pulse polarity = ~last_pol; last_pol := that polarity.
  - 11: pulse polarity = last_pol; last_pol unchanged.
  - polarity 1 drives hdb3_p = 1; polarity 0 drives hdb3_n = 1.
  - hdb3_p and hdb3_n are never both 1.
- All outputs are registered. err is registered and aligned to the input edge that caused it, not to the output symbol.
- Simultaneous events: the parity update and the B decision on a V edge both use the pre-edge mark_odd value.

Test Plan:
- Reset, then data_v = 01,00,00,00,11:
  - mark count odd, no B;
  - from cycle 4: code_out = 01,00,00,00,11;
  - p/n = P,0,0,0,P.
- Continue with 00,00,00,11:
  - even (zero) marks, so B is inserted;
  - code_out = 10,00,00,11;
  - p/n = N,0,0,N.
- Continue with 01,01,00,00,00,11:
  - two marks (even), so B is inserted;
  - marks/B/V alternate correctly: code_out = 01,01,10,00,00,11;
  - p/n = P,N,P,0,0,P.
- Inject 10 mid-stream:
  - err pulses one cycle later;
  - output shows 00 in that slot;
  - parity unchanged.
- V after only one zero (01,00,11) with mark_odd = 0:
  - no B;
  - err = 1;
  - V emitted with same polarity as the previous mark.
- Assert rst_n low for one cycle mid-sequence:
  - next 3 output cycles are 00 with p = n = 0;
  - first subsequent mark is positive (INIT_POL = 0).

Source files
------------

// File: rtl/hdb3_b_polar.sv
// HDB3 encoder back end: inserts the B pulse ahead of a V when the mark count
// since the previous V is even, assigns alternating polarity and drives P/N rails.
module hdb3_b_polar #(
  parameter logic INIT_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] data_v,
  output logic [1:0] code_out,
  output logic       hdb3_p,
  output logic       hdb3_n,
  output logic       err
);

  logic [1:0] sr0, sr1, sr2;
  logic       mark_odd;
  logic       last_pol;

  logic [1:0] din;
  logic       zeros3;
  logic       is_v;
  logic       b_ins;
  logic [1:0] out_sym;
  logic       pulse_pol;
  logic       is_pulse;

  always_comb begin
    din       = (data_v == 2'b10) ? 2'b00 : data_v;
    zeros3    = (sr0 == 2'b00) && (sr1 == 2'b00) && (sr2 == 2'b00);
    is_v      = (data_v == 2'b11);
    // B replaces the oldest of the three zeros that precede the incoming V
    b_ins     = is_v && !mark_odd && zeros3;
    out_sym   = b_ins ? 2'b10 : sr2;
    is_pulse  = (out_sym != 2'b00);
    pulse_pol = last_pol;
    if (out_sym == 2'b01 || out_sym == 2'b10) begin
      pulse_pol = ~last_pol;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr0      <= 2'b00;
      sr1      <= 2'b00;
      sr2      <= 2'b00;
      code_out <= 2'b00;
      hdb3_p   <= 1'b0;
      hdb3_n   <= 1'b0;
      err      <= 1'b0;
      mark_odd <= 1'b0;
      last_pol <= INIT_POL;
    end else begin
      sr0      <= din;
      sr1      <= sr0;
      sr2      <= sr1;
      code_out <= out_sym;
      hdb3_p   <= is_pulse && pulse_pol;
      hdb3_n   <= is_pulse && !pulse_pol;
      if (out_sym == 2'b01 || out_sym == 2'b10) begin
        last_pol <= pulse_pol;
      end
      if (data_v == 2'b01) begin
        mark_odd <= ~mark_odd;
      end else if (data_v == 2'b11) begin
        mark_odd <= 1'b0;
      end
      // flags the offending input edge, not the output slot
      err <= (data_v == 2'b10) || (is_v && !zeros3);
    end
  end

endmodule

// File: tb/tb_hdb3_b_polar.sv
// Directed-vector bench for hdb3_b_polar: each row drives one symbol and checks
// the registered outputs after that edge against hand-computed values.
module tb_hdb3_b_polar;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] data_v = 2'b00;
  logic [1:0] code_out;
  logic       hdb3_p;
  logic       hdb3_n;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  hdb3_b_polar #(.INIT_POL(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_v   (data_v),
    .code_out (code_out),
    .hdb3_p   (hdb3_p),
    .hdb3_n   (hdb3_n),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] d, input logic [1:0] c,
                      input logic p, input logic n, input logic e);
    @(negedge clk);
    rst_n  = r;
    data_v = d;
    @(posedge clk);
    #1;
    cyc++;
    check($sformatf("code c%0d", cyc), code_out, c);
    check($sformatf("p c%0d", cyc), {1'b0, hdb3_p}, {1'b0, p});
    check($sformatf("n c%0d", cyc), {1'b0, hdb3_n}, {1'b0, n});
    check($sformatf("err c%0d", cyc), {1'b0, err}, {1'b0, e});
  endtask

  initial begin
    // reset: all outputs quiet
    step(1'b0, 2'b01, 2'b00, 0, 0, 0);
    step(1'b0, 2'b11, 2'b00, 0, 0, 0);
    cyc = 0;
    // 01 000 V: odd marks, no B
    step(1, 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b01, 1, 0, 0);
    step(1, 2'b11, 2'b00, 0, 0, 0);
    // 000 V: zero marks, B inserted
    step(1, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b11, 1, 0, 0);
    step(1, 2'b11, 2'b10, 0, 1, 0);
    // 01 01 000 V: two marks, B inserted
    step(1, 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b11, 0, 1, 0);
    step(1, 2'b00, 2'b01, 1, 0, 0);
    step(1, 2'b00, 2'b01, 0, 1, 0);
    step(1, 2'b11, 2'b10, 1, 0, 0);
    // 01 then illegal 10 (as 00): parity stays odd, so the V gets no B
    step(1, 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b10, 2'b00, 0, 0, 1);
    step(1, 2'b00, 2'b11, 1, 0, 0);
    step(1, 2'b00, 2'b01, 0, 1, 0);
    step(1, 2'b11, 2'b00, 0, 0, 0);
    // 01 01 00 V: V too early -> err, no B, V same polarity as last mark
    step(1, 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b11, 0, 1, 0);
    step(1, 2'b11, 2'b01, 1, 0, 1);
    step(1, 2'b00, 2'b01, 0, 1, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b11, 0, 1, 0);
    // mark in flight, then one-cycle reset discards it
    step(1, 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    // first mark after reset is positive again
    step(1, 2'b00, 2'b01, 1, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
